rand_seq_ctrl: RTL
==================

RAND_SEQ_CTRL -- requirements
Module: rand_seq_ctrl

Interface
REQ-001 SHALL have parameter MIN_SPIN, default 16: minimum SPIN cycles before a press is accepted; range 1..255.
REQ-002 SHALL have parameter HOLD_CYC, default 4: HOLD-state length in cycles; range 1..255.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a 4-digit code build.
REQ-006 SHALL have port btn_press  input  1  debounced one-cycle press pulse that captures a digit.
REQ-007 SHALL have port abort  input  1  one-cycle pulse that cancels the build.
REQ-008 SHALL have port ack  input  1  consumer acknowledges a finished code.
REQ-009 SHALL have port rand_in  input  4  digit from the random generator.
REQ-010 SHALL have port gen_stop  output  1  registered; 1 freezes the generator.
REQ-011 SHALL have port code_out  output  16  four BCD digits; digit k occupies bits [4k+3:4k].
REQ-012 SHALL have port digit_idx  output  2  index of the digit currently being built.
REQ-013 SHALL have port busy  output  1  high in SPIN, CAPTURE and HOLD.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement the states IDLE, SPIN, CAPTURE, HOLD and DONE, all with registered outputs.
REQ-016 IDLE: gen_stop=1; on start -> SPIN, with code_out=0, digit_idx=0 and the spin counter cleared.
REQ-017 SPIN: gen_stop=0; the spin counter increments and saturates at MIN_SPIN.
REQ-018 SPIN: btn_press with counter==MIN_SPIN -> CAPTURE; a press before then SHALL be ignored and not queued.
REQ-019 CAPTURE: gen_stop=1 for one cycle; the nibble digit_idx is written with rand_in if rand_in<=9, else with rand_in-10; -> HOLD.
REQ-020 HOLD: gen_stop=1 for exactly HOLD_CYC cycles; then, if digit_idx==3 -> DONE; otherwise digit_idx increments, the spin counter clears, and the FSM returns to SPIN.
REQ-021 DONE: done=1 and code_out stable until ack; ack -> IDLE with code_out preserved; start in DONE SHALL be ignored.
REQ-022 Latency: gen_stop falls on the first edge after start and rises on the first edge after an accepted press.
REQ-023 abort in any non-IDLE state -> IDLE on the next edge, with code_out=0, digit_idx=0 and gen_stop=1.
REQ-024 Priority SHALL be reset > abort > ack > start > btn_press; start and btn_press together in IDLE SHALL take start only.
REQ-025 btn_press outside SPIN, and start outside IDLE, SHALL have no effect.
REQ-026 Counters SHALL be 8-bit and SHALL NOT wrap.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, gen_stop=1, code_out=16'h0000, digit_idx=0, busy=0, done=0, and all counters to 0.
REQ-028 Reset mid-build SHALL discard all partial digits, with no residual output on release.

Configuration
REQ-029 Macro RAND_SEQ_DUP_REJECT_EN defined: in CAPTURE, a (mapped) digit equal to any already-captured digit of this build SHALL NOT be written; the FSM returns to SPIN with the counter cleared and digit_idx unchanged, and HOLD is skipped.
REQ-030 Macro RAND_SEQ_DUP_REJECT_EN undefined: duplicate digits SHALL be accepted, and no comparison logic SHALL be present.

Verification
REQ-031 MIN_SPIN=16, HOLD_CYC=4; start, presses 20 cycles apart with rand_in=3,7,1,9 -> code_out=16'h9173, done=1, gen_stop=1.
REQ-032 Press 5 cycles after entering SPIN (MIN_SPIN=16) -> ignored, state stays SPIN, digit_idx=0.
REQ-033 rand_in=4'd12 at capture -> nibble=2.
REQ-034 abort during the HOLD of digit 2 -> next cycle IDLE, code_out=0, busy=0; reset asserted during SPIN -> outputs at reset values asynchronously.
REQ-035 DONE, start pulse -> no change; ack -> IDLE with code_out retained.
REQ-036 RAND_SEQ_DUP_REJECT_EN defined: captures 5,5,2,8,0 -> second 5 rejected with digit_idx staying 1; final code_out=16'h0825.

Source files
------------

// File: rtl/rand_seq_ctrl.sv
// rtl/rand_seq_ctrl.sv - four-digit random code builder driven by button presses
// Optional RAND_SEQ_DUP_REJECT_EN: reject captured digits already present in the current build.
module rand_seq_ctrl #(
  parameter int MIN_SPIN = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_press,
  input  logic        abort,
  input  logic        ack,
  input  logic [3:0]  rand_in,
  output logic        gen_stop,
  output logic [15:0] code_out,
  output logic [1:0]  digit_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SPIN, CAPTURE, HOLD, DONE} state_t;

  localparam logic [7:0] SPIN_MAX  = 8'(MIN_SPIN);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] spin_cnt;
  logic [7:0] hold_cnt;
  logic [3:0] mapped;

  // Out-of-range generator values 10..15 fold back onto 0..5.
  assign mapped = (rand_in <= 4'd9) ? rand_in : rand_in - 4'd10;

`ifdef RAND_SEQ_DUP_REJECT_EN
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if ((2'(k) < digit_idx) && (code_out[4*k +: 4] == mapped)) dup = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gen_stop  <= 1'b1;
      code_out  <= 16'h0000;
      digit_idx <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spin_cnt  <= 8'd0;
      hold_cnt  <= 8'd0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      gen_stop  <= 1'b1;
      code_out  <= 16'h0000;
      digit_idx <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spin_cnt  <= 8'd0;
      hold_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SPIN;
            code_out  <= 16'h0000;
            digit_idx <= 2'd0;
            spin_cnt  <= 8'd0;
            gen_stop  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SPIN: begin
          if (spin_cnt != SPIN_MAX) spin_cnt <= spin_cnt + 8'd1;
          if (btn_press && spin_cnt == SPIN_MAX) begin
            state    <= CAPTURE;
            gen_stop <= 1'b1;
          end
        end
        CAPTURE: begin
`ifdef RAND_SEQ_DUP_REJECT_EN
          if (dup) begin
            state    <= SPIN;
            spin_cnt <= 8'd0;
            gen_stop <= 1'b0;
          end else begin
            code_out[{digit_idx, 2'b00} +: 4] <= mapped;
            hold_cnt <= 8'd0;
            state    <= HOLD;
          end
`else
          code_out[{digit_idx, 2'b00} +: 4] <= mapped;
          hold_cnt <= 8'd0;
          state    <= HOLD;
`endif
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 8'd0;
            if (digit_idx == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              digit_idx <= digit_idx + 2'd1;
              spin_cnt  <= 8'd0;
              gen_stop  <= 1'b0;
              state     <= SPIN;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
